wb_arbiter2: RTL and testbench

//  Two-master, one-slave Wishbone arbiter with round-robin fairness. It shares one

---
 rtl/wb_arbiter2.sv | 172 +++++++++++++++++
 tb/tb_wb_arbiter2.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter with round-robin fairness.
// m0 = instruction fetch, m1 = data port. The grant is registered; address,
// control and write data are muxed combinationally from the owner, and ack/err
// are routed back to the owner only.
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the stalled-strobe
// timeout (TO_CYC cycles) that errors the owner and releases the bus.
module wb_arbiter2 #(
    parameter int unsigned AW     = 32,
    parameter int unsigned DW     = 32,
    parameter int unsigned SW     = 2,
    parameter int unsigned TO_CYC = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    input  logic          m0_we_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic          m0_tga_i,
    input  logic          m0_stb_i,
    input  logic          m0_cyc_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    input  logic          m1_we_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic          m1_tga_i,
    input  logic          m1_stb_i,
    input  logic          m1_cyc_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    output logic          s_we_o,
    output logic [SW-1:0] s_sel_o,
    output logic          s_tga_o,
    output logic          s_stb_o,
    output logic          s_cyc_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);

    localparam int unsigned CNT_W =
        ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   last_owner;       // 0 = m0 released last, 1 = m1 released last
    logic   last_owner_nxt;
    logic   owner_stb_c;
    logic   owner_ack_c;
    logic   timeout_hit_c;

    // Owner strobe and a slave ack that is qualified by that strobe
    assign owner_stb_c = ((state == OWN0) && m0_stb_i) || ((state == OWN1) && m1_stb_i);
    assign owner_ack_c = owner_stb_c && s_ack_i;

    // Read data is broadcast; only ack tells a master it is valid
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

`ifdef WB_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;

    // Fires in the cycle that would be the TO_CYC-th consecutive stalled one
    assign timeout_hit_c = owner_stb_c && (to_cnt == CNT_W'(TO_CYC - 1));
    assign m0_err_o      = timeout_hit_c && (state == OWN0);
    assign m1_err_o      = timeout_hit_c && (state == OWN1);

    // Stall counter: cleared on ack, ownership change or idle; counts unacked strobes
    always_ff @(posedge clk_i) begin
        if (rst_i || (state == IDLE) || (state_nxt != state) || owner_ack_c) begin
            to_cnt <= '0;
        end else if (owner_stb_c) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end
`else
    logic [CNT_W-1:0] unused_to_cyc;

    assign unused_to_cyc = CNT_W'(TO_CYC);
    assign timeout_hit_c = 1'b0;
    assign m0_err_o      = 1'b0;
    assign m1_err_o      = 1'b0;
`endif

    // State, fairness pointer and registered grant
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_owner <= 1'b0;
            gnt_o      <= 2'b00;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            gnt_o      <= {state_nxt == OWN1, state_nxt == OWN0};
        end
    end

    // Next-state: round-robin on ties, hold while cyc, direct hand-over on release
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_nxt = OWN0;
                end else if (m1_cyc_i) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i || timeout_hit_c) begin
                    last_owner_nxt = 1'b0;
                    state_nxt      = m1_cyc_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc_i || timeout_hit_c) begin
                    last_owner_nxt = 1'b1;
                    state_nxt      = m0_cyc_i ? OWN0 : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slave-side mux and owner-only ack; a reset cycle forwards no ack
    always_comb begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_tga_o  = m0_tga_i;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state)
            OWN0: begin
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i && !timeout_hit_c;
                s_stb_o  = m0_stb_i && !timeout_hit_c;
                m0_ack_o = owner_ack_c && !timeout_hit_c && !rst_i;
            end
            OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_tga_o  = m1_tga_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i && !timeout_hit_c;
                s_stb_o  = m1_stb_i && !timeout_hit_c;
                m1_ack_o = owner_ack_c && !timeout_hit_c && !rst_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Self-checking bench for wb_arbiter2: per-master scoreboards of expected read
// data, plus scenario tasks for grant order, burst hold, reset and timeout.
module tb_wb_arbiter2;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 2;
    localparam logic [31:0] WKEY = 32'hA5A5_0000;

    logic          clk;
    logic          rst_i;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_dat, m1_dat;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_we, m1_we;
    logic [SW-1:0] m0_sel, m1_sel;
    logic          m0_tga, m1_tga;
    logic          m0_stb, m1_stb;
    logic          m0_cyc, m1_cyc;
    logic          m0_ack_o, m1_ack_o;
    logic          m0_err_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_we_o;
    logic [SW-1:0] s_sel_o;
    logic          s_tga_o;
    logic          s_stb_o;
    logic          s_cyc_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;
    logic [1:0]    gnt_o;
    logic          slave_en;

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] q0[$];
    logic [AW-1:0] q1[$];

    wb_arbiter2 #(.AW(AW), .DW(DW), .SW(SW), .TO_CYC(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we),
        .m0_sel_i(m0_sel), .m0_tga_i(m0_tga), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we),
        .m1_sel_i(m1_sel), .m1_tga_i(m1_tga), .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_tga_o(s_tga_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait slave: read data is the inverted address
    assign s_ack_i = s_cyc_o && s_stb_o && slave_en;
    assign s_dat_i = ~s_adr_o;

    // Scoreboard: each ack pops the owner's expected address and checks read data
    always @(negedge clk) begin
        if (m0_ack_o) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL m0_unexpected_ack adr=%h", s_adr_o);
            end else begin
                logic [AW-1:0] ea;
                ea = q0.pop_front();
                if (m0_dat_o !== ~ea || s_adr_o !== ea) begin
                    errors++;
                    $display("FAIL m0_beat got adr=%h dat=%h want adr=%h dat=%h",
                             s_adr_o, m0_dat_o, ea, ~ea);
                end
            end
        end
        if (m1_ack_o) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL m1_unexpected_ack adr=%h", s_adr_o);
            end else begin
                logic [AW-1:0] ea;
                ea = q1.pop_front();
                if (m1_dat_o !== ~ea || s_adr_o !== ea) begin
                    errors++;
                    $display("FAIL m1_beat got adr=%h dat=%h want adr=%h dat=%h",
                             s_adr_o, m1_dat_o, ea, ~ea);
                end
            end
        end
    end

    // One master transaction of nb beats; gap idle-strobe cycles after beat 0
    task automatic xfer(input int m, input int nb, input logic [AW-1:0] base,
                        input logic we, input int gap);
        for (int b = 0; b < nb; b++) begin
            logic [AW-1:0] a;
            logic got;
            int n;
            a = base + 32'(4 * b);
            if (m == 0) begin
                m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = a; m0_we = we;
                m0_dat = a ^ WKEY; m0_sel = 2'b11; m0_tga = b[0];
                q0.push_back(a);
            end else begin
                m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = a; m1_we = we;
                m1_dat = a ^ WKEY; m1_sel = 2'b10; m1_tga = ~b[0];
                q1.push_back(a);
            end
            got = 1'b0;
            n = 0;
            while (!got && n < 50) begin
                @(negedge clk);
                got = (m == 0) ? m0_ack_o : m1_ack_o;
                if (!got) begin
                    @(posedge clk); #1;
                end
                n++;
            end
            if (!got) begin
                checks++; errors++;
                $display("FAIL ack_wait m%0d adr=%h got no ack want ack within 50 cycles", m, a);
            end
            @(posedge clk); #1;
            if (m == 0) m0_stb = 1'b0; else m1_stb = 1'b0;
            if (b == 0) repeat (gap) begin @(posedge clk); #1; end
        end
        if (m == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        m0_adr = 32'h55; m1_adr = 32'hAA; m0_sel = 2'b01; m1_sel = 2'b10;
        m0_cyc = 1'b0; m1_cyc = 1'b0; m0_stb = 1'b0; m1_stb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_we_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl gnt=%b cyc=%b stb=%b we=%b want 00 0 0 0",
                     gnt_o, s_cyc_o, s_stb_o, s_we_o);
        end
        checks++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ack ack/err=%b want 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
        end
        checks++;
        if (s_adr_o !== 32'h55 || s_sel_o !== 2'b01) begin
            errors++;
            $display("FAIL reset_mux adr=%h sel=%b want 00000055 01", s_adr_o, s_sel_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;
    endtask

    task automatic test_single();
        fork
            xfer(0, 1, 32'h10, 1'b0, 0);
            begin
                @(negedge clk);
                checks++;
                if (gnt_o !== 2'b00 || m0_ack_o !== 1'b0) begin
                    errors++;
                    $display("FAIL single_c0 gnt=%b ack=%b want 00 0", gnt_o, m0_ack_o);
                end
                @(negedge clk);
                checks++;
                if (gnt_o !== 2'b01 || m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0 || s_adr_o !== 32'h10) begin
                    errors++;
                    $display("FAIL single_c1 gnt=%b ack0=%b ack1=%b adr=%h want 01 1 0 00000010",
                             gnt_o, m0_ack_o, m1_ack_o, s_adr_o);
                end
            end
        join
    endtask

    task automatic test_tie();
        fork
            xfer(0, 1, 32'h20, 1'b0, 0);
            xfer(1, 1, 32'h30, 1'b1, 0);
            begin
                @(negedge clk);
                @(negedge clk);
                checks++;
                if (gnt_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
                    errors++;
                    $display("FAIL tie_first gnt=%b ack1=%b ack0=%b want 10 1 0", gnt_o, m1_ack_o, m0_ack_o);
                end
                checks++;
                if (s_we_o !== 1'b1 || s_dat_o !== (32'h30 ^ WKEY) || s_sel_o !== 2'b10 || s_tga_o !== 1'b1) begin
                    errors++;
                    $display("FAIL tie_mux we=%b dat=%h sel=%b tga=%b want 1 %h 10 1",
                             s_we_o, s_dat_o, s_sel_o, s_tga_o, 32'h30 ^ WKEY);
                end
                @(negedge clk);
                checks++;
                if (gnt_o !== 2'b10 || s_cyc_o !== 1'b0) begin
                    errors++;
                    $display("FAIL tie_release gnt=%b cyc=%b want 10 0", gnt_o, s_cyc_o);
                end
                @(negedge clk);
                checks++;
                if (gnt_o !== 2'b01 || m0_ack_o !== 1'b1) begin
                    errors++;
                    $display("FAIL tie_handover gnt=%b ack0=%b want 01 1", gnt_o, m0_ack_o);
                end
            end
        join
    endtask

    task automatic test_alternate();
        logic [1:0] seq[$];
        logic [1:0] want[4];
        want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b10; want[3] = 2'b01;
        fork
            begin xfer(0, 1, 32'h40, 1'b0, 0); xfer(0, 1, 32'h44, 1'b0, 0); end
            begin xfer(1, 1, 32'h80, 1'b0, 0); xfer(1, 1, 32'h84, 1'b0, 0); end
            begin
                logic [1:0] prev;
                prev = 2'b00;
                for (int i = 0; i < 30; i++) begin
                    @(negedge clk);
                    if (gnt_o != 2'b00 && gnt_o != prev) begin
                        seq.push_back(gnt_o);
                        prev = gnt_o;
                    end
                end
            end
        join
        checks++;
        if (seq.size() != 4) begin
            errors++;
            $display("FAIL alt_count got %0d grants want 4", seq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (seq[i] !== want[i]) begin
                    errors++;
                    $display("FAIL alt_order idx=%0d got %b want %b", i, seq[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_burst_hold();
        logic m0_seen, m1_seen;
        m0_seen = 1'b0; m1_seen = 1'b0;
        fork
            xfer(0, 3, 32'h100, 1'b1, 2);
            begin
                repeat (2) begin @(posedge clk); #1; end
                xfer(1, 1, 32'h200, 1'b0, 0);
            end
            begin
                for (int i = 0; i < 25; i++) begin
                    @(negedge clk);
                    if (gnt_o == 2'b01) m0_seen = 1'b1;
                    if (gnt_o == 2'b10) m1_seen = 1'b1;
                    if (m0_seen && m0_cyc) begin
                        checks++;
                        if (gnt_o !== 2'b01 || m1_ack_o !== 1'b0) begin
                            errors++;
                            $display("FAIL burst_hold cyc=%0d gnt=%b ack1=%b want 01 0", i, gnt_o, m1_ack_o);
                        end
                    end
                end
            end
        join
        checks++;
        if (m1_seen !== 1'b1) begin
            errors++;
            $display("FAIL burst_m1_served got %b want 1", m1_seen);
        end
    endtask

    task automatic test_reset_mid();
        slave_en = 1'b0;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h300; m1_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt_o !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_owner gnt=%b want 10", gnt_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b1; slave_en = 1'b1;
        @(negedge clk);
        checks++;
        if (m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_inflight ack1=%b want 0", m1_ack_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt_o !== 2'b00 || s_cyc_o !== 1'b0 || m1_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after gnt=%b cyc=%b ack1=%b want 00 0 0", gnt_o, s_cyc_o, m1_ack_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        slave_en = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h400;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 7) begin
                checks++;
                if (gnt_o !== 2'b01 || m0_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL to_stall k=%0d gnt=%b err=%b want 01 0", k, gnt_o, m0_err_o);
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            if (k == 8) begin
                checks++;
                if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
                    errors++;
                    $display("FAIL to_fire err0=%b err1=%b cyc=%b stb=%b want 1 0 0 0",
                             m0_err_o, m1_err_o, s_cyc_o, s_stb_o);
                end
            end
            if (k == 9) begin
                checks++;
                if (gnt_o !== 2'b10 || m0_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL to_next gnt=%b err0=%b want 10 0", gnt_o, m0_err_o);
                end
            end
`else
            if (k == 8) begin
                checks++;
                if (m0_err_o !== 1'b0 || s_cyc_o !== 1'b1) begin
                    errors++;
                    $display("FAIL to_off_err err0=%b cyc=%b want 0 1", m0_err_o, s_cyc_o);
                end
            end
            if (k == 9) begin
                checks++;
                if (gnt_o !== 2'b01) begin
                    errors++;
                    $display("FAIL to_off_hold gnt=%b want 01", gnt_o);
                end
            end
`endif
            @(posedge clk); #1;
            if (k == 1) begin
                m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h500;
            end
        end
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        slave_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst_i = 1'b1; slave_en = 1'b1;
        m0_adr = '0; m0_dat = '0; m0_we = 1'b0; m0_sel = '0; m0_tga = 1'b0;
        m0_stb = 1'b0; m0_cyc = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_we = 1'b0; m1_sel = '0; m1_tga = 1'b0;
        m1_stb = 1'b0; m1_cyc = 1'b0;
        test_reset();
        test_single();
        test_reset();
        test_tie();
        test_alternate();
        test_burst_hold();
        test_reset_mid();
        test_timeout();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left m0=%0d m1=%0d want 0 0", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
